// File: rtl/xgmii_pkt_gen.sv
// XGMII test-frame burst generator: preamble, fixed header, sequence/timestamp, FCS.
// Optional `CRC_GEN_EN fills the FCS with a real CRC-32; otherwise it is zero.
`timescale 1ns/1ps

module xgmii_pkt_gen #(
    parameter logic [47:0] MAC_SA    = 48'h00_11_22_33_44_55,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [15:0] frame_cnt,
    input  logic [7:0]  frame_words,
    input  logic [7:0]  gap_words,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        busy,
    output logic [31:0] sent_cnt
);

    localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
    localparam logic [63:0] PRE_WORD  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD = 64'h07070707070707FD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_TERM,
        ST_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  fw_q, fw_d;
    logic [7:0]  gw_q, gw_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] ts_q;
    logic [31:0] ts_cap_q, ts_cap_d;
    logic [31:0] sent_q, sent_d;
    logic        busy_q, busy_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;

    logic [63:0] word_w;
    logic [31:0] fcs_w;
    logic        last_w;

    // Byte-reverse so the most significant byte lands in the lowest lane
    function automatic logic [31:0] be32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    assign last_w = (idx_q == fw_q - 8'd1);

`ifdef CRC_GEN_EN
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32 over the low nb bytes of d, lane 0 first
    function automatic logic [31:0] crc_upd(
        input logic [31:0] c,
        input logic [63:0] d,
        input int          nb
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (i < nb) begin
                r = r ^ {24'h0, d[8*i +: 8]};
                for (int b = 0; b < 8; b++) begin
                    r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
                end
            end
        end
        return r;
    endfunction

    // Running CRC over every data word before the FCS word
    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_PRE) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (state_q == ST_DATA && !last_w) begin
            crc_d = crc_upd(crc_q, word_w, 8);
        end
    end

    // CRC accumulator register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    // Last word's first four lanes are zero, fold them in before complementing
    assign fcs_w = ~crc_upd(crc_q, 64'h0, 4);
`else
    assign fcs_w = 32'h0;
`endif

    // Payload word for the current DATA index
    always_comb begin
        word_w = 64'h0;
        if (idx_q == 8'd0) begin
            word_w = {MAC_SA[39:32], MAC_SA[47:40], 48'hFFFF_FFFF_FFFF};
        end else if (idx_q == 8'd1) begin
            word_w = {16'h0, ETHERTYPE[7:0], ETHERTYPE[15:8],
                      be32(MAC_SA[31:0])};
        end else if (idx_q == 8'd2) begin
            word_w = {be32(ts_cap_q), be32(seq_q)};
        end else if (last_w) begin
            word_w = {fcs_w, 32'h0};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        fw_d     = fw_q;
        gw_d     = gw_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        ts_cap_d = ts_cap_q;
        sent_d   = sent_q;
        txd_d    = IDLE_WORD;
        txc_d    = 8'hFF;
        unique case (state_q)
            ST_IDLE: begin
                if (start && frame_cnt != 16'd0) begin
                    state_d = ST_PRE;
                    rem_d   = frame_cnt;
                    fw_d    = (frame_words < 8'd8) ? 8'd8 : frame_words;
                    gw_d    = (gap_words < 8'd1) ? 8'd1 : gap_words;
                    seq_d   = 32'd0;
                end
            end
            ST_PRE: begin
                txd_d    = PRE_WORD;
                txc_d    = 8'h01;
                ts_cap_d = ts_q;
                idx_d    = 8'd0;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                txd_d = word_w;
                txc_d = 8'h00;
                idx_d = idx_q + 8'd1;
                if (last_w) begin
                    idx_d   = 8'd0;
                    state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                txd_d   = TERM_WORD;
                sent_d  = sent_q + 32'd1;
                seq_d   = seq_q + 32'd1;
                rem_d   = rem_q - 16'd1;
                idx_d   = 8'd0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (idx_q == gw_q - 8'd1) begin
                    idx_d   = 8'd0;
                    state_d = (rem_q != 16'd0) ? ST_PRE : ST_IDLE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Free-running timestamp
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ts_q <= 32'd0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    // Control state, counters and registered wire outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= 16'd0;
            fw_q     <= 8'd8;
            gw_q     <= 8'd1;
            idx_q    <= 8'd0;
            seq_q    <= 32'd0;
            ts_cap_q <= 32'd0;
            sent_q   <= 32'd0;
            busy_q   <= 1'b0;
            txd_q    <= IDLE_WORD;
            txc_q    <= 8'hFF;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            fw_q     <= fw_d;
            gw_q     <= gw_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            ts_cap_q <= ts_cap_d;
            sent_q   <= sent_d;
            busy_q   <= busy_d;
            txd_q    <= txd_d;
            txc_q    <= txc_d;
        end
    end

    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign busy      = busy_q;
    assign sent_cnt  = sent_q;

endmodule

// File: tb/tb_xgmii_pkt_gen.sv
// Directed bench for xgmii_pkt_gen: vector table for one frame plus
// hand-written burst, clamp, ignored-start and mid-frame reset sequences.
`timescale 1ns/1ps

module tb_xgmii_pkt_gen;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W = 64'h07070707070707FD;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame_cnt = 16'd0;
    logic [7:0]  frame_words = 8'd8;
    logic [7:0]  gap_words = 8'd1;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        busy;
    logic [31:0] sent_cnt;

    xgmii_pkt_gen dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (start),
        .frame_cnt   (frame_cnt),
        .frame_words (frame_words),
        .gap_words   (gap_words),
        .xgmii_txd   (xgmii_txd),
        .xgmii_txc   (xgmii_txc),
        .busy        (busy),
        .sent_cnt    (sent_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        busy;
    } vec_t;

    vec_t        tbl[16];
    logic [63:0] cd[64];
    logic [7:0]  cc[64];
    logic        cb[64];
    int          pre_q[$];
    int          fd_q[$];
    int          nbusy;
    int          nonidle;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_fcs;
    logic [31:0] s0, s1, s2, t0, t1, t2;
    logic [7:0]  fb[60];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] be32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

`ifdef CRC_GEN_EN
    function automatic logic [31:0] crc_ref(input logic [7:0] b[60]);
        logic [31:0] r;
        logic        f;
        r = 32'hFFFF_FFFF;
        for (int k = 0; k < 60; k++) begin
            for (int j = 0; j < 8; j++) begin
                f = r[0] ^ b[k][j];
                r = r >> 1;
                if (f) r = r ^ 32'hEDB88320;
            end
        end
        return r;
    endfunction
`endif

    // Called just after a rising edge; cycle 0 carries the start pulse.
    task automatic burst(input logic [15:0] fc, input logic [7:0] fw,
                         input logic [7:0] gw, input int n,
                         input int p1, input int p2);
        for (int c = 0; c < n; c++) begin
            start = (c == 0) || (c == p1) || (c == p2);
            if (c == 0) begin
                frame_cnt   = fc;
                frame_words = fw;
                gap_words   = gw;
            end else begin
                frame_cnt   = 16'd5;
                frame_words = 8'd20;
                gap_words   = 8'd9;
            end
            @(negedge sys_clk);
            cd[c] = xgmii_txd;
            cc[c] = xgmii_txc;
            cb[c] = busy;
            @(posedge sys_clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic scan(input int n);
        pre_q.delete();
        fd_q.delete();
        nbusy   = 0;
        nonidle = 0;
        for (int i = 0; i < n; i++) begin
            if (cc[i] == 8'h01 && cd[i] == PRE_W) pre_q.push_back(i);
            if (cc[i] == 8'hFF && cd[i] == TERM_W) fd_q.push_back(i);
            if (cb[i]) nbusy++;
            if (!(cc[i] == 8'hFF && cd[i] == IDLE_W)) nonidle++;
        end
    endtask

    initial begin
        // One 64-byte frame, gap 2, start driven after 4 edges -> ts = 5
        for (int i = 0; i < 16; i++) tbl[i] = '{IDLE_W, 8'hFF, 1'b0};
        tbl[1]  = '{IDLE_W, 8'hFF, 1'b1};
        tbl[2]  = '{PRE_W,  8'h01, 1'b1};
        tbl[3]  = '{64'h1100_FFFF_FFFF_FFFF, 8'h00, 1'b1};
        tbl[4]  = '{64'h0000_B588_5544_3322, 8'h00, 1'b1};
        tbl[5]  = '{64'h0500_0000_0000_0000, 8'h00, 1'b1};
        for (int i = 6; i < 11; i++) tbl[i] = '{64'h0, 8'h00, 1'b1};
        tbl[11] = '{TERM_W, 8'hFF, 1'b1};
        tbl[12] = '{IDLE_W, 8'hFF, 1'b1};
`ifdef CRC_GEN_EN
        for (int k = 0; k < 56; k++) fb[k] = tbl[3 + k / 8].txd[8 * (k % 8) +: 8];
        for (int k = 56; k < 60; k++) fb[k] = 8'h00;
        exp_fcs = ~crc_ref(fb);
`else
        for (int k = 0; k < 60; k++) fb[k] = 8'h00;
        exp_fcs = 32'h0;
`endif
        tbl[10].txd = {exp_fcs, 32'h0};

        // Reset state
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset txd", xgmii_txd, IDLE_W);
        chk("reset txc", {56'h0, xgmii_txc}, 64'hFF);
        chk("reset busy", {63'h0, busy}, 64'h0);
        chk("reset sent", {32'h0, sent_cnt}, 64'h0);
        sys_rst_n = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;

        // Single frame against the vector table
        burst(16'd1, 8'd8, 8'd2, 16, -1, -1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t1 txd[%0d]", i), cd[i], tbl[i].txd);
            chk($sformatf("t1 txc[%0d]", i), {56'h0, cc[i]}, {56'h0, tbl[i].txc});
            chk($sformatf("t1 busy[%0d]", i), {63'h0, cb[i]}, {63'h0, tbl[i].busy});
        end
        scan(16);
        chk("t1 busy cycles", nbusy, 12);
        chk("t1 sent", {32'h0, sent_cnt}, 64'd1);

        // Three frames, 10 words, gap 3
        burst(16'd3, 8'd10, 8'd3, 56, -1, -1);
        scan(56);
        chk("t2 pre count", pre_q.size(), 3);
        chk("t2 term count", fd_q.size(), 3);
        if (pre_q.size() == 3 && fd_q.size() == 3) begin
            chk("t2 first pre", pre_q[0], 2);
            chk("t2 spacing 1", pre_q[1] - pre_q[0], 15);
            chk("t2 spacing 2", pre_q[2] - pre_q[1], 15);
            for (int k = 0; k < 3; k++)
                chk($sformatf("t2 term pos %0d", k), fd_q[k] - pre_q[k], 11);
            s0 = be32(cd[pre_q[0] + 3][31:0]);
            s1 = be32(cd[pre_q[1] + 3][31:0]);
            s2 = be32(cd[pre_q[2] + 3][31:0]);
            t0 = be32(cd[pre_q[0] + 3][63:32]);
            t1 = be32(cd[pre_q[1] + 3][63:32]);
            t2 = be32(cd[pre_q[2] + 3][63:32]);
            chk("t2 seq 0", {32'h0, s0}, 64'd0);
            chk("t2 seq 1", {32'h0, s1}, 64'd1);
            chk("t2 seq 2", {32'h0, s2}, 64'd2);
            chk("t2 ts diff 1", {32'h0, t1 - t0}, 64'd15);
            chk("t2 ts diff 2", {32'h0, t2 - t1}, 64'd15);
        end
        chk("t2 sent", {32'h0, sent_cnt}, 64'd4);

        // Clamping: 3 words -> 8, gap 0 -> 1
        burst(16'd2, 8'd3, 8'd0, 30, -1, -1);
        scan(30);
        chk("t3 pre count", pre_q.size(), 2);
        if (pre_q.size() == 2 && fd_q.size() == 2) begin
            chk("t3 spacing", pre_q[1] - pre_q[0], 11);
            chk("t3 term pos", fd_q[0] - pre_q[0], 9);
        end
        chk("t3 sent", {32'h0, sent_cnt}, 64'd6);

        // Start while busy and on the final gap cycle; cfg churn mid-burst
        burst(16'd2, 8'd8, 8'd1, 32, 5, 22);
        scan(32);
        chk("t4 pre count", pre_q.size(), 2);
        chk("t4 busy cycles", nbusy, 22);
        chk("t4 sent", {32'h0, sent_cnt}, 64'd8);

        // frame_cnt = 0 launches nothing
        burst(16'd0, 8'd8, 8'd2, 20, -1, -1);
        scan(20);
        chk("t4b nonidle", nonidle, 0);
        chk("t4b busy cycles", nbusy, 0);
        chk("t4b sent", {32'h0, sent_cnt}, 64'd8);

        // Reset while data word 4 is on the wire
        start       = 1'b1;
        frame_cnt   = 16'd1;
        frame_words = 8'd8;
        gap_words   = 8'd2;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1;
        chk("t5 mid-frame txc", {56'h0, xgmii_txc}, 64'h0);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("t5 rst txd", xgmii_txd, IDLE_W);
        chk("t5 rst txc", {56'h0, xgmii_txc}, 64'hFF);
        chk("t5 rst busy", {63'h0, busy}, 64'h0);
        chk("t5 rst sent", {32'h0, sent_cnt}, 64'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        burst(16'd0, 8'd8, 8'd2, 20, -1, -1);
        scan(20);
        chk("t5 nonidle after", nonidle, 0);
        chk("t5 no term", fd_q.size(), 0);
        chk("t5 sent after", {32'h0, sent_cnt}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
